// File: rtl/instruction_prefetch_buffer.sv
// Sequential instruction fetch with a single outstanding req/gnt/rvalid transaction
// and a small FIFO that feeds decode; branches flush the FIFO and drop in-flight data.
module instruction_prefetch_buffer #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  input  logic                  branch_i,
  input  logic [ADDR_WIDTH-1:0] branch_addr_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  busy_o,
  output logic                  instr_req_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [DATA_WIDTH-1:0] instr_rdata_i
);

  localparam int                    PTR_W      = $clog2(DEPTH);
  localparam int                    CNT_W      = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]      FULL       = CNT_W'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] WORD       = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   fetch_addr_q, fetch_addr_d;
  logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic                    discard_q, discard_d;
  logic [DATA_WIDTH-1:0]   data_mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0]   addr_mem_q [DEPTH];

  logic grant;
  logic resp;
  logic push;
  logic pop;

  // Decode handshake: an entry transfers on a cycle where valid_o and ready_i are both
  // high; valid_o never drops without a transfer except on a branch flush.
  assign valid_o = (count_q != '0);
  assign rdata_o = data_mem_q[rd_ptr_q];
  assign addr_o  = addr_mem_q[rd_ptr_q];
  assign busy_o  = (state_q != IDLE);

  always_comb begin
    instr_req_o = 1'b0;
    case (state_q)
      IDLE:     instr_req_o = req_i & (count_q < FULL) & ~branch_i;
      WAIT_GNT: instr_req_o = 1'b1;
      default:  instr_req_o = 1'b0;
    endcase
    // While waiting for grant the address must stay put even if a branch moved fetch_addr.
    instr_addr_o = (state_q == WAIT_GNT) ? req_addr_q : fetch_addr_q;

    grant = instr_req_o & instr_gnt_i;
    resp  = (state_q == WAIT_RVALID) & instr_rvalid_i;
    push  = resp & ~discard_q & ~branch_i;
    pop   = valid_o & ready_i & ~branch_i;

    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    req_addr_d   = req_addr_q;
    discard_d    = discard_q;

    case (state_q)
      IDLE: begin
        if (instr_req_o) begin
          req_addr_d = fetch_addr_q;
          if (instr_gnt_i) begin
            state_d      = WAIT_RVALID;
            fetch_addr_d = fetch_addr_q + WORD;
          end else begin
            state_d = WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        if (instr_gnt_i) begin
          state_d = WAIT_RVALID;
          if (!discard_q) fetch_addr_d = fetch_addr_q + WORD;
        end
      end
      WAIT_RVALID: begin
        if (instr_rvalid_i) begin
          state_d   = IDLE;
          discard_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (branch_i) begin
      fetch_addr_d = branch_addr_i & ALIGN_MASK;
      if ((state_q == WAIT_GNT) || ((state_q == WAIT_RVALID) && !instr_rvalid_i)) begin
        discard_d = 1'b1;
      end
    end

    if (branch_i) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fetch_addr_q <= BOOT_ADDR;
      req_addr_q   <= BOOT_ADDR;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      discard_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      req_addr_q   <= req_addr_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      discard_q    <= discard_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_q[i] <= '0;
        addr_mem_q[i] <= '0;
      end
    end else if (push) begin
      data_mem_q[wr_ptr_q] <= instr_rdata_i;
      addr_mem_q[wr_ptr_q] <= req_addr_q;
    end
  end

endmodule

// File: tb/tb_instruction_prefetch_buffer.sv
// Bench for instruction_prefetch_buffer: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based model of the fetch stream.
module tb_instruction_prefetch_buffer;

  localparam int          AW    = 32;
  localparam int          DW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BOOT  = 32'h0;

  logic          clk;
  logic          rst_n;
  logic          req_i;
  logic          branch_i;
  logic [AW-1:0] branch_addr_i;
  logic          ready_i;
  logic          valid_o;
  logic [DW-1:0] rdata_o;
  logic [AW-1:0] addr_o;
  logic          busy_o;
  logic          instr_req_o;
  logic [AW-1:0] instr_addr_o;
  logic          instr_gnt_i;
  logic          instr_rvalid_i;
  logic [DW-1:0] instr_rdata_i;

  instruction_prefetch_buffer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .BOOT_ADDR(BOOT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .branch_i(branch_i),
    .branch_addr_i(branch_addr_i), .ready_i(ready_i), .valid_o(valid_o),
    .rdata_o(rdata_o), .addr_o(addr_o), .busy_o(busy_o),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
    .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i(instr_rdata_i)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memdata(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // ---------------- stimulus knobs and memory responder ----------------
  int          req_pct = 100, ready_pct = 100, gnt_pct = 100, br_pct = 0;
  int          rsp_min = 0, rsp_max = 0;
  int          force_ready = -1;
  logic        hold_gnt = 1'b0, force_branch = 1'b0, force_stray = 1'b0;
  logic [31:0] force_br_addr = '0;
  logic        gnt_seen = 1'b0, mem_busy = 1'b0;
  logic [31:0] gnt_addr = '0, mem_addr = '0;
  int          mem_dly = 0;
  logic [31:0] grant_log[$];
  logic [31:0] del_log[$];

  function automatic logic [31:0] at_g(input int i);
    return (i < grant_log.size()) ? grant_log[i] : 32'hDEAD_DEAD;
  endfunction

  function automatic logic [31:0] at_d(input int i);
    return (i < del_log.size()) ? del_log[i] : 32'hDEAD_DEAD;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
    if (gnt_seen) begin
      mem_busy = 1'b1;
      mem_addr = gnt_addr;
      mem_dly  = $urandom_range(rsp_max, rsp_min);
    end
    gnt_seen       = 1'b0;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = $urandom;
    if (mem_busy) begin
      if (mem_dly == 0) begin
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = memdata(mem_addr);
        mem_busy       = 1'b0;
      end else begin
        mem_dly--;
      end
    end
    if (force_stray) begin
      instr_rvalid_i = 1'b1;
      force_stray    = 1'b0;
    end
    req_i = ($urandom_range(0, 99) < req_pct);
    if (force_ready >= 0) begin
      ready_i     = force_ready[0];
      force_ready = -1;
    end else begin
      ready_i = ($urandom_range(0, 99) < ready_pct);
    end
    if (force_branch) begin
      branch_i      = 1'b1;
      branch_addr_i = force_br_addr;
      force_branch  = 1'b0;
    end else begin
      branch_i      = ($urandom_range(0, 99) < br_pct);
      branch_addr_i = $urandom;
    end
    if (valid_o && ready_i && !branch_i) del_log.push_back(addr_o);
    #1;
    gnt_seen    = instr_req_o && !hold_gnt && ($urandom_range(0, 99) < gnt_pct);
    instr_gnt_i = gnt_seen;
    if (gnt_seen) begin
      gnt_addr = instr_addr_o;
      grant_log.push_back(instr_addr_o);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    req_i = 0; branch_i = 0; ready_i = 0; instr_gnt_i = 0; instr_rvalid_i = 0;
    rst_n = 0;
    gnt_seen = 0; mem_busy = 0; hold_gnt = 0;
    grant_log.delete();
    del_log.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  // ---------------- reference model and scoreboard ----------------
  logic [63:0] exp_q[$];
  logic [31:0] m_fetch, m_cur, e_addr, n_fetch;
  logic        m_wait_gnt, m_wait_rsp, m_drop;
  logic        e_req, m_idle, m_rsp, n_drop;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_fetch    = BOOT;
      m_cur      = BOOT;
      m_wait_gnt = 1'b0;
      m_wait_rsp = 1'b0;
      m_drop     = 1'b0;
    end else begin
      m_idle = !m_wait_gnt && !m_wait_rsp;
      e_req  = m_idle ? (req_i && (exp_q.size() < DEPTH) && !branch_i) : m_wait_gnt;
      e_addr = m_wait_gnt ? m_cur : m_fetch;
      check("instr_req", instr_req_o, e_req);
      check("instr_addr", instr_addr_o, e_addr);
      check("busy", busy_o, !m_idle);
      check("valid", valid_o, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("addr_o", addr_o, exp_q[0][63:32]);
        check("rdata_o", rdata_o, exp_q[0][31:0]);
      end

      m_rsp   = m_wait_rsp && instr_rvalid_i;
      n_fetch = m_fetch;
      if (e_req && instr_gnt_i && !m_drop) n_fetch = m_fetch + 32'd4;
      if (branch_i) n_fetch = branch_addr_i & ~32'd3;
      n_drop = m_drop;
      if (m_rsp) n_drop = 1'b0;
      if (branch_i && (m_wait_gnt || (m_wait_rsp && !instr_rvalid_i))) n_drop = 1'b1;

      if (branch_i) begin
        exp_q.delete();
      end else begin
        if (exp_q.size() != 0 && ready_i) void'(exp_q.pop_front());
        if (m_rsp && !m_drop) exp_q.push_back({m_cur, memdata(m_cur)});
      end

      if (m_idle && e_req) begin
        m_cur = m_fetch;
        if (instr_gnt_i) m_wait_rsp = 1'b1;
        else             m_wait_gnt = 1'b1;
      end else if (m_wait_gnt && instr_gnt_i) begin
        m_wait_gnt = 1'b0;
        m_wait_rsp = 1'b1;
      end else if (m_rsp) begin
        m_wait_rsp = 1'b0;
      end
      m_fetch = n_fetch;
      m_drop  = n_drop;
    end
  end

  // ---------------- directed and random scenarios ----------------
  initial begin
    rst_n = 1; req_i = 0; branch_i = 0; branch_addr_i = '0; ready_i = 0;
    instr_gnt_i = 0; instr_rvalid_i = 0; instr_rdata_i = '0;
    #1 rst_n = 0;
    #1;
    check("rst_valid", valid_o, 1'b0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_addr", addr_o, 32'h0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_req", instr_req_o, 1'b0);
    check("rst_iaddr", instr_addr_o, BOOT);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1;

    // Sequential stream, immediate grant, response one cycle later.
    cycle();
    check("first_req", instr_req_o, 1'b1);
    check("first_iaddr", instr_addr_o, BOOT);
    repeat (11) cycle();
    check("stream_grants", grant_log.size(), 6);
    for (int i = 0; i < 4; i++) begin
      check("stream_gaddr", at_g(i), 32'(4 * i));
      check("stream_daddr", at_d(i), 32'(4 * i));
    end

    // Backpressure: four credits, then one pop frees exactly one request.
    do_reset();
    ready_pct = 0;
    repeat (20) cycle();
    check("bp_grants", grant_log.size(), 4);
    check("bp_req_low", instr_req_o, 1'b0);
    check("bp_valid", valid_o, 1'b1);
    force_ready = 1;
    cycle();
    repeat (10) cycle();
    check("bp_grants_after_pop", grant_log.size(), 5);
    check("bp_new_addr", at_g(4), 32'h10);
    check("bp_deliveries", del_log.size(), 1);

    // Grant stall on the request to 0x8.
    do_reset();
    ready_pct = 100;
    for (int i = 0; i < 50 && grant_log.size() < 2; i++) cycle();
    check("stall_setup", grant_log.size(), 2);
    cycle();
    hold_gnt = 1;
    repeat (3) begin
      cycle();
      check("stall_req", instr_req_o, 1'b1);
      check("stall_iaddr", instr_addr_o, 32'h8);
    end
    hold_gnt = 0;
    repeat (6) cycle();
    check("stall_gaddr", at_g(2), 32'h8);
    check("stall_next", at_g(3), 32'hC);
    check("stall_daddr", at_d(2), 32'h8);

    // Branch while waiting for rvalid; target low bits are masked.
    do_reset();
    rsp_min = 2; rsp_max = 2;
    for (int i = 0; i < 50 && grant_log.size() < 1; i++) cycle();
    check("brv_setup", grant_log.size(), 1);
    force_branch = 1; force_br_addr = 32'h88C3_200B;
    cycle();
    rsp_min = 0; rsp_max = 0;
    cycle();
    check("brv_valid_low", valid_o, 1'b0);
    check("brv_busy", busy_o, 1'b1);
    repeat (15) cycle();
    check("brv_target_req", at_g(1), 32'h88C3_2008);
    check("brv_first_del", at_d(0), 32'h88C3_2008);
    check("brv_second_del", at_d(1), 32'h88C3_200C);

    // Branch while waiting for grant on 0x10.
    do_reset();
    for (int i = 0; i < 50 && grant_log.size() < 4; i++) cycle();
    check("brg_setup", grant_log.size(), 4);
    cycle();
    hold_gnt = 1;
    cycle();
    check("brg_held_addr", instr_addr_o, 32'h10);
    force_branch = 1; force_br_addr = 32'h200;
    cycle();
    check("brg_branch_req", instr_req_o, 1'b1);
    check("brg_branch_addr", instr_addr_o, 32'h10);
    cycle();
    check("brg_after_addr", instr_addr_o, 32'h10);
    check("brg_after_valid", valid_o, 1'b0);
    hold_gnt = 0;
    repeat (10) cycle();
    check("brg_old_grant", at_g(4), 32'h10);
    check("brg_target_grant", at_g(5), 32'h200);
    check("brg_first_after", at_d(4), 32'h200);

    // Branch, pop and rvalid all in the same cycle.
    do_reset();
    ready_pct = 0;
    for (int i = 0; i < 50 && grant_log.size() < 2; i++) cycle();
    check("bpr_setup", grant_log.size(), 2);
    req_pct = 0;
    force_branch = 1; force_br_addr = 32'h300; force_ready = 1;
    cycle();
    check("bpr_pre_valid", valid_o, 1'b1);
    check("bpr_rvalid", instr_rvalid_i, 1'b1);
    cycle();
    check("bpr_valid", valid_o, 1'b0);
    check("bpr_busy", busy_o, 1'b0);
    repeat (3) cycle();
    check("bpr_still_empty", valid_o, 1'b0);

    // Branch in IDLE suppresses the request; fetch wraps past the top of memory.
    do_reset();
    req_pct = 100; ready_pct = 100;
    force_branch = 1; force_br_addr = 32'hFFFF_FFFE;
    cycle();
    check("bri_req_suppressed", instr_req_o, 1'b0);
    repeat (8) cycle();
    check("wrap_first", at_g(0), 32'hFFFF_FFFC);
    check("wrap_second", at_g(1), 32'h0);

    // Reset in the middle of a transaction, then a stray rvalid.
    do_reset();
    rsp_min = 3; rsp_max = 3;
    for (int i = 0; i < 50 && grant_log.size() < 1; i++) cycle();
    check("rmt_setup", grant_log.size(), 1);
    cycle();
    #1;
    req_i = 0; instr_gnt_i = 0; instr_rvalid_i = 0;
    rst_n = 0;
    #1;
    check("rmt_busy", busy_o, 1'b0);
    check("rmt_valid", valid_o, 1'b0);
    check("rmt_req", instr_req_o, 1'b0);
    check("rmt_iaddr", instr_addr_o, BOOT);
    gnt_seen = 0; mem_busy = 0;
    grant_log.delete();
    del_log.delete();
    @(posedge clk);
    #1 rst_n = 1;
    rsp_min = 0; rsp_max = 0;
    req_pct = 0; force_stray = 1;
    cycle();
    req_pct = 100;
    repeat (8) cycle();
    check("rmt_first_grant", at_g(0), BOOT);
    check("rmt_first_del", at_d(0), BOOT);

    // Randomized traffic.
    do_reset();
    for (int blk = 0; blk < 30; blk++) begin
      req_pct   = $urandom_range(100, 50);
      ready_pct = $urandom_range(100, 0);
      gnt_pct   = $urandom_range(100, 20);
      rsp_min   = 0;
      rsp_max   = $urandom_range(4, 0);
      br_pct    = $urandom_range(8, 0);
      repeat (100) cycle();
    end
    br_pct = 0; req_pct = 100; ready_pct = 100; gnt_pct = 100;
    repeat (20) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    bad++;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
